// File: rtl/seq_divider.sv
// Radix-2 restoring sequential divider (quotient/remainder, RISC-V M semantics).
// Signed DIV/REM support is compiled in only when DIV_SIGNED_EN is defined.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // state | meaning
   // IDLE  | waiting for start; result holds last answer
   // CALC  | one restoring iteration per cycle, quotient MSB first
   // FIN   | result valid, done pulses for this one cycle
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             rem_sel_q, rem_sel_d;
`ifdef DIV_SIGNED_EN
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
`endif

   logic             div_zero;
   logic             ovf;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH-1:0] iter_quo, iter_rem;
   logic [WIDTH-1:0] fin_val;

   assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
   assign a_neg = op[1] & dividend[WIDTH-1];
   assign b_neg = op[1] & divisor[WIDTH-1];
   assign ovf   = op[1] & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
   assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
   assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;
`else
   logic unused_op1;
   assign unused_op1 = op[1];
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
   assign ovf   = 1'b0;
   assign a_mag = dividend;
   assign b_mag = divisor;
`endif

   // Partial remainder is always below the divisor, so WIDTH+1 bits hold the
   // shifted value and the sign of the difference is a clean borrow flag.
   assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
   assign q_bit    = ~trial[WIDTH];
   assign iter_rem = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign iter_quo = {quo_q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
   always_comb begin
      fin_val = '0;
      if (rem_sel_q) fin_val = neg_rem_q ? (~iter_rem + 1'b1) : iter_rem;
      else           fin_val = neg_quo_q ? (~iter_quo + 1'b1) : iter_quo;
   end
`else
   assign fin_val = rem_sel_q ? iter_rem : iter_quo;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      rem_sel_d = rem_sel_q;
`ifdef DIV_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               quo_d     = a_mag;
               rem_d     = '0;
               dvs_d     = b_mag;
               cnt_d     = CW'(WIDTH - 1);
               rem_sel_d = op[0];
`ifdef DIV_SIGNED_EN
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
`endif
               if (div_zero) begin
                  state_d  = FIN;
                  result_d = op[0] ? dividend : '1;
               end else if (ovf) begin
                  state_d  = FIN;
                  result_d = op[0] ? '0 : dividend;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            quo_d = iter_quo;
            rem_d = iter_rem;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d  = FIN;
               result_d = fin_val;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         rem_sel_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         rem_sel_q <= rem_sel_d;
`ifdef DIV_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FIN);
   assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected result and latency,
// a negedge monitor pops and checks on every done pulse.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done;
   logic [31:0] result;

   seq_divider #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Latency is counted as edges from the accepting edge to the edge that samples done.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         done_cnt++;
         checks++;
         if (prev_done) begin
            failures++;
            $display("FAIL done_width: done high on consecutive cycles at cyc %0d (need single pulse)", cyc);
         end
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done at cyc %0d with nothing outstanding, result=%h", cyc, result);
         end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
               failures++;
               $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
            end
            checks++;
            if (cyc + 1 - e.acc != e.lat) begin
               failures++;
               $display("FAIL %s latency: got %0d edges expected %0d", e.name, cyc + 1 - e.acc, e.lat);
            end
         end
      end
      prev_done = done;
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: busy still %b after %0d cycles (need 0)", busy, n);
      end
   endtask

   task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                        output int acc);
      exp_t e;
      wait_idle();
      op       = o;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
      e.res = exp_res; e.acc = acc; e.lat = lat; e.name = name;
      sb.push_back(e);
   endtask

   // Each vector carries the signed-build and unsigned-build expectations.
   task automatic vec(input string name, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res_s, input int lat_s,
                      input logic [31:0] res_u, input int lat_u);
      int acc;
`ifdef DIV_SIGNED_EN
      issue(name, o, a, b, res_s, lat_s, acc);
`else
      issue(name, o, a, b, res_u, lat_u, acc);
`endif
   endtask

   initial begin
      int acc;
      int dc;
      int n;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b result=%h (need 0 0 0)", busy, done, result);
      end

      //     name          op     dividend      divisor       signed res    lat  unsigned res  lat
      vec("divu_100_7",  2'b00, 32'd100,      32'd7,        32'd14,       33, 32'd14,       33);
      vec("remu_100_7",  2'b01, 32'd100,      32'd7,        32'd2,        33, 32'd2,        33);
      vec("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 32'h7FFFFFFC, 33);
      vec("rem_m7_2",    2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 32'd1,        33);
      vec("divu_5_0",    2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  32'hFFFFFFFF, 1);
      vec("remu_5_0",    2'b01, 32'd5,        32'd0,        32'd5,        1,  32'd5,        1);
      vec("div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  32'h0,        33);
      vec("rem_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  32'h80000000, 33);
      vec("div_20_m3",   2'b10, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, 32'h0,        33);
      vec("rem_m20_3",   2'b11, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, 32'd2,        33);
      vec("divu_max_1",  2'b00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 32'hFFFFFFFF, 33);
      vec("div_0_0",     2'b10, 32'd0,        32'd0,        32'hFFFFFFFF, 1,  32'hFFFFFFFF, 1);
      vec("rem_m5_0",    2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  32'hFFFFFFFB, 1);
      vec("divu_3_5",    2'b00, 32'd3,        32'd5,        32'd0,        33, 32'd0,        33);

      // Start pulsed mid-operation with different operands must be ignored.
      issue("ignored_start", 2'b00, 32'd100, 32'd7, 32'd14, 33, acc);
      repeat (9) @(posedge clk);
      #1;
      dividend = 32'd200;
      divisor  = 32'd3;
      op       = 2'b01;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      // Reset at edge 15 of an operation aborts it with no done pulse.
      wait_idle();
      op = 2'b00; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL abort_reset: busy=%b done=%b result=%h (need 0 0 0)", busy, done, result);
      end
      dc = done_cnt;
      repeat (40) @(negedge clk);
      checks++;
      if (done_cnt != dc) begin
         failures++;
         $display("FAIL abort_no_done: %0d done pulses after abort (need 0)", done_cnt - dc);
      end

      vec("after_abort", 2'b01, 32'd1000, 32'd3, 32'd1, 33, 32'd1, 33);

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results never returned (need 0)", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (XLEN); only 32 is verified.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port: op  input  2  op[0]=1 remainder, 0 quotient; op[1]=1 signed, 0 unsigned.
REQ-006 SHALL have port: dividend  input  WIDTH  sampled with start.
REQ-007 SHALL have port: divisor  input  WIDTH  sampled with start.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done deasserts.
REQ-009 SHALL have port: done  output  1  single-cycle result-valid pulse.
REQ-010 SHALL have port: result  output  WIDTH  quotient or remainder per op; held until the next accepted start.

Function
REQ-011 SHALL implement RISC-V M semantics: DIVU/REMU, DIV/REM (truncate toward zero; remainder takes dividend sign).
REQ-012 SHALL be a radix-2 restoring divider: one quotient bit per cycle, MSB first, via WIDTH+1-bit trial subtract of the partial remainder.
REQ-013 SHALL use FSM states IDLE, CALC, FIN; IDLE->CALC on accepted start, CALC->FIN after WIDTH iterations, FIN->IDLE unconditionally.
REQ-014 SHALL latch operands and op on the edge that samples start=1 in IDLE; signed ops convert operands to magnitudes at latch.
REQ-015 SHALL assert done exactly WIDTH+1 edges after the accepting edge (33 for WIDTH=32), for exactly one cycle, in FIN.
REQ-016 SHALL register result on the edge entering FIN, applying sign correction (negate quotient if signs differ, negate remainder if dividend negative).
REQ-017 SHALL ignore start while busy=1; operands in flight are not disturbed.
REQ-018 SHALL accept a new start in the cycle IDLE is re-entered (back-to-back: next done 1+WIDTH+1 edges after previous done).
REQ-019 SHALL treat divisor=0 as fast path: IDLE->FIN directly, done 1 edge after accept; quotient=all ones, remainder=dividend.
REQ-020 SHALL treat signed overflow (dividend=most-negative, divisor=-1) as fast path, done 1 edge after accept; quotient=dividend, remainder=0.
REQ-021 SHALL never raise exceptions; all cases produce a defined result.

Reset
REQ-022 SHALL, with rst=1 at an edge, force IDLE, busy=0, done=0, result=0, clearing all internal registers; start concurrent with rst is ignored.
REQ-023 SHALL abort any in-flight division on reset without producing done.

Configuration
REQ-024 SHALL gate signed support with macro DIV_SIGNED_EN.
REQ-025 SHALL, with DIV_SIGNED_EN defined, honour op[1] per REQ-011, REQ-016, REQ-020.
REQ-026 SHALL, without DIV_SIGNED_EN, ignore op[1]: all ops unsigned, no sign-correction or overflow logic synthesized; divide-by-zero fast path retained.

Verification
REQ-027 SHALL cover: DIVU 100/7 start at edge 0 -> done at edge 33, result=14; REMU same -> result=2.
REQ-028 SHALL cover: DIV -7/2 -> result=-3 (0xFFFFFFFD); REM -7/2 -> result=-1 (0xFFFFFFFF).
REQ-029 SHALL cover: DIVU 5/0 -> done 1 edge after accept, result=0xFFFFFFFF; REMU 5/0 -> result=5.
REQ-030 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> done 1 edge after accept, result=0x80000000; REM -> result=0.
REQ-031 SHALL cover: start pulsed with new operands at edge 10 of an op -> ignored, original result returned; rst at edge 15 -> busy=0, done never pulses, result=0.
REQ-032 SHALL cover: without DIV_SIGNED_EN, op=2'b10 on 0xFFFFFFF9/2 -> result=0x7FFFFFFC (unsigned).
